memory_ram_loadable: RTL and testbench



---
 rtl/memory_pkg.sv | 7 +
 rtl/memory_boot_loader.sv | 63 ++++++
 rtl/memory_ram_loadable.sv | 71 +++++++
 tb/tb_memory_ram_loadable.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared state encoding and sizing helpers for the loadable RAM
package memory_pkg;
  typedef enum logic {LOAD, RUN} mem_state_t;
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/memory_boot_loader.sv
// memory_boot_loader: packs a byte stream into words and writes them from address 0 upward
module memory_boot_loader
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS = 13,
  parameter int LOAD_ENABLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  boot_done,
  output logic [ADDR_BITS:0]    loaded_words,
  output logic                  write_enable,
  output logic [ADDR_BITS-1:0]  write_address,
  output logic [DATA_WIDTH-1:0] write_word
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  localparam mem_state_t RESET_STATE = (LOAD_ENABLE != 0) ? LOAD : RUN;
  mem_state_t state, next_state;
  logic [CW-1:0] byte_count;
  logic [DATA_WIDTH-1:0] assembly, word;
  logic [ADDR_BITS-1:0] pointer;
  logic accept, commit, done;
  assign accept = load_valid & load_ready;
  assign commit = accept & (load_last | (byte_count == CW'(BPW - 1)));
  assign done = commit & (load_last | (pointer == '1));
  assign word = assembly | (DATA_WIDTH'(load_byte) << {byte_count, 3'b000});
  // state register; RUN is terminal until reset
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= RESET_STATE;
    else state <= next_state;
  // leave LOAD on the commit that ends the image or fills the last address
  always_comb next_state = (state == LOAD && done) ? RUN : state;
  // control outputs decode directly from state; commit writes the word being completed
  always_comb begin
    load_ready = state == LOAD;
    boot_done = state == RUN;
    write_enable = commit;
    write_address = pointer;
    write_word = word;
  end
  // byte counter, word assembler, pointer and committed-word count; a partial word is dropped on reset
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      byte_count <= '0;
      assembly <= '0;
      pointer <= '0;
      loaded_words <= '0;
    end else if (commit) begin
      byte_count <= '0;
      assembly <= '0;
      pointer <= pointer + ADDR_BITS'(1);
      loaded_words <= loaded_words + (ADDR_BITS + 1)'(1);
    end else if (accept) begin
      byte_count <= byte_count + CW'(1);
      assembly <= word;
    end
endmodule

// File: rtl/memory_ram_loadable.sv
// memory_ram_loadable: dual-port program/data RAM with a byte-stream boot loader
module memory_ram_loadable
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS = 13,
  parameter int LOAD_ENABLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  boot_done,
  output logic [ADDR_BITS:0]    loaded_words,
  input  logic [ADDR_BITS-1:0]  instruction_address,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  input  logic [ADDR_BITS-1:0]  memory_address,
  input  logic                  memory_write_enable,
  input  logic [DATA_WIDTH-1:0] memory_data_in,
  output logic [DATA_WIDTH-1:0] memory_data_out
);
  if (bytes_per_word(DATA_WIDTH) * 8 != DATA_WIDTH) begin : g_width_check
    $error("DATA_WIDTH must be a multiple of 8");
  end
  logic [DATA_WIDTH-1:0] ram [2**ADDR_BITS];
  logic loader_we, ram_we;
  logic [ADDR_BITS-1:0] loader_address, ram_address;
  logic [DATA_WIDTH-1:0] loader_word, ram_data;
  logic data_we;
  memory_boot_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .LOAD_ENABLE(LOAD_ENABLE)
  ) u_loader (
    .clock(clock),
    .reset(reset),
    .load_valid(load_valid),
    .load_byte(load_byte),
    .load_last(load_last),
    .load_ready(load_ready),
    .boot_done(boot_done),
    .loaded_words(loaded_words),
    .write_enable(loader_we),
    .write_address(loader_address),
    .write_word(loader_word)
  );
  // the loader owns the write port in LOAD, the data port owns it in RUN
  always_comb begin
    data_we = boot_done & memory_write_enable;
    ram_we = loader_we | data_we;
    ram_address = boot_done ? memory_address : loader_address;
    ram_data = boot_done ? memory_data_in : loader_word;
  end
  // RAM contents are never reset
  always_ff @(posedge clock)
    if (ram_we) ram[ram_address] <= ram_data;
  // registered read ports with write-first forwarding; both stay 0 until RUN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      instruction <= '0;
      memory_data_out <= '0;
      instruction_valid <= 1'b0;
    end else if (boot_done) begin
      memory_data_out <= memory_write_enable ? memory_data_in : ram[memory_address];
      instruction <= (memory_write_enable && instruction_address == memory_address) ? memory_data_in : ram[instruction_address];
      instruction_valid <= 1'b1;
    end
endmodule

// File: tb/tb_memory_ram_loadable.sv
// tb_memory_ram_loadable: directed checks of loader, read ports and forwarding
module tb_memory_ram_loadable;
  logic clock = 1'b0;
  logic reset;
  logic load_valid, load_last, load_ready, boot_done, instruction_valid, memory_write_enable;
  logic [7:0] load_byte;
  logic [13:0] loaded_words;
  logic [12:0] instruction_address, memory_address;
  logic [15:0] instruction, memory_data_in, memory_data_out;
  logic s_load_valid, s_load_last, s_load_ready, s_boot_done, s_instruction_valid, s_memory_write_enable;
  logic [7:0] s_load_byte;
  logic [2:0] s_loaded_words;
  logic [1:0] s_instruction_address, s_memory_address;
  logic [15:0] s_instruction, s_memory_data_in, s_memory_data_out;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  memory_ram_loadable dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .boot_done(boot_done), .loaded_words(loaded_words),
    .instruction_address(instruction_address), .instruction(instruction),
    .instruction_valid(instruction_valid), .memory_address(memory_address),
    .memory_write_enable(memory_write_enable), .memory_data_in(memory_data_in),
    .memory_data_out(memory_data_out)
  );
  memory_ram_loadable #(.DATA_WIDTH(16), .ADDR_BITS(2), .LOAD_ENABLE(1)) dut_small (
    .clock(clock), .reset(reset),
    .load_valid(s_load_valid), .load_byte(s_load_byte), .load_last(s_load_last),
    .load_ready(s_load_ready), .boot_done(s_boot_done), .loaded_words(s_loaded_words),
    .instruction_address(s_instruction_address), .instruction(s_instruction),
    .instruction_valid(s_instruction_valid), .memory_address(s_memory_address),
    .memory_write_enable(s_memory_write_enable), .memory_data_in(s_memory_data_in),
    .memory_data_out(s_memory_data_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic l);
    load_valid = 1'b1;
    load_byte = b;
    load_last = l;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask
  task automatic send_small(input logic [7:0] b, input logic l);
    s_load_valid = 1'b1;
    s_load_byte = b;
    s_load_last = l;
    tick();
    s_load_valid = 1'b0;
    s_load_last = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    {load_valid, load_last, memory_write_enable} = '0;
    load_byte = '0;
    instruction_address = '0;
    memory_address = '0;
    memory_data_in = '0;
    {s_load_valid, s_load_last, s_memory_write_enable} = '0;
    s_load_byte = '0;
    s_instruction_address = '0;
    s_memory_address = '0;
    s_memory_data_in = '0;
    tick();
    reset = 1'b0;
    check("reset_loaded_words", loaded_words, 0);
    check("reset_boot_done", boot_done, 0);
    check("reset_load_ready", load_ready, 1);
    check("reset_instruction", instruction, 0);
    check("reset_data_out", memory_data_out, 0);
    check("reset_instr_valid", instruction_valid, 0);
    memory_write_enable = 1'b1;
    memory_address = 13'd0;
    memory_data_in = 16'hFFFF;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    check("partial_loaded_words", loaded_words, 1);
    check("load_data_out_zero", memory_data_out, 0);
    check("load_instr_zero", instruction, 0);
    send(8'h33, 1'b0);
    do_reset();
    check("midload_reset_words", loaded_words, 0);
    check("midload_reset_ready", load_ready, 1);
    send(8'h44, 1'b0);
    send(8'h55, 1'b1);
    memory_write_enable = 1'b0;
    check("reload_words", loaded_words, 1);
    check("reload_boot_done", boot_done, 1);
    check("reload_ready_low", load_ready, 0);
    check("reload_instr_valid_lag", instruction_valid, 0);
    tick();
    check("reload_ram0_data", memory_data_out, 16'h5544);
    check("reload_ram0_instr", instruction, 16'h5544);
    check("reload_instr_valid", instruction_valid, 1);
    do_reset();
    memory_write_enable = 1'b1;
    memory_address = 13'd0;
    memory_data_in = 16'hFFFF;
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    send(8'h78, 1'b0);
    send(8'h56, 1'b1);
    memory_write_enable = 1'b0;
    check("four_byte_words", loaded_words, 2);
    check("four_byte_boot_done", boot_done, 1);
    instruction_address = 13'd1;
    memory_address = 13'd0;
    tick();
    check("fetch_addr1", instruction, 16'h5678);
    check("ram0_kept_loader", memory_data_out, 16'h1234);
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    check("early_end_words", loaded_words, 2);
    check("early_end_boot_done", boot_done, 1);
    instruction_address = 13'd0;
    memory_address = 13'd1;
    tick();
    check("early_end_zero_fill", memory_data_out, 16'h00CC);
    check("early_end_ram0", instruction, 16'hBBAA);
    memory_write_enable = 1'b1;
    memory_address = 13'd5;
    memory_data_in = 16'hBEEF;
    instruction_address = 13'd5;
    tick();
    memory_write_enable = 1'b0;
    memory_data_in = 16'h0000;
    check("fwd_instruction", instruction, 16'hBEEF);
    check("fwd_data_out", memory_data_out, 16'hBEEF);
    instruction_address = 13'd1;
    tick();
    check("write_persisted", memory_data_out, 16'hBEEF);
    check("fetch_after_write", instruction, 16'h00CC);
    check("instr_valid_held", instruction_valid, 1);
    for (int i = 1; i <= 7; i++) send_small(8'(i), 1'b0);
    check("small_words_before_fill", s_loaded_words, 3);
    check("small_ready_before_fill", s_load_ready, 1);
    send_small(8'h08, 1'b0);
    check("small_words_full", s_loaded_words, 4);
    check("small_boot_done", s_boot_done, 1);
    check("small_ready_low", s_load_ready, 0);
    send_small(8'h99, 1'b1);
    check("small_run_ignores_load", s_loaded_words, 4);
    s_memory_address = 2'd3;
    s_instruction_address = 2'd0;
    tick();
    check("small_ram3", s_memory_data_out, 16'h0807);
    check("small_ram0", s_instruction, 16'h0201);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
